// File: rtl/neurocam_host_if_if.sv
// Request channel between the neurocam host front end and the CAM core.
//   req_valid : command request pending
//   req_op    : 01=WRITE, 10=SEARCH, 11=CLEAR
//   req_addr  : target CAM entry
//   req_data  : write data / search key, first payload byte in the MSBs
//   req_ready : CAM core accepts the request
// master: host front end (drives the request), slave: CAM core (drives ready).
interface neurocam_host_if_if #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned WORD_W = 16
);
  logic              req_valid;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_data;
  logic              req_ready;

  modport master (
    output req_valid,
    output req_op,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_op,
    input  req_addr,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/neurocam_host_if.sv
// Host-side command framer for the neurocam CAM core.
// Bytes arrive on byte_in, qualified by an asynchronous strobe (strb_in) that is
// synchronised and edge-detected. A command byte (op in [7:6], addr in [ADDR_W-1:0])
// is optionally followed by WORD_BYTES payload bytes; the finished command is held
// on the req channel until the core accepts it.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   ena         : when low, strobe edges are ignored and all state holds
//   byte_in     : host data byte
//   strb_in     : host byte strobe (asynchronous)
//   req         : request channel (master modport)
//   busy        : framer not idle
//   ovf         : sticky, a byte arrived while a request was pending and was dropped
//   tmo         : sticky, payload inter-byte timeout abort
// Optional feature macro: NEUROCAM_TIMEOUT_EN enables the payload timeout; without it
// PAYLOAD waits forever and tmo is tied low.
module neurocam_host_if #(
  parameter int unsigned WORD_BYTES  = 2,
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic [7:0]                byte_in,
  input  logic                      strb_in,
  neurocam_host_if_if.master        req,
  output logic                      busy,
  output logic                      ovf,
  output logic                      tmo
);

  localparam int unsigned WORD_W = 8 * WORD_BYTES;
  localparam int unsigned CntW   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  if (ADDR_W == 0 || ADDR_W > 6) begin : g_bad_addr_w
    $error("ADDR_W must be in 1..6");
  end
  if (WORD_BYTES == 0 || TIMEOUT_CYC == 0) begin : g_bad_cfg
    $error("WORD_BYTES and TIMEOUT_CYC must be non-zero");
  end

  typedef enum logic [1:0] {StIdle, StPayload, StIssue} state_e;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              s1_q, s2_q, s3_q;
  logic              byte_evt;

`ifdef NEUROCAM_TIMEOUT_EN
  localparam int unsigned TmrW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [TmrW-1:0]   tmr_q, tmr_d;
  logic              tmo_q, tmo_d;
`endif

  // Two-flop synchroniser plus edge flop; s1/s2/s3 run regardless of ena so
  // edges seen while disabled are consumed rather than replayed later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= strb_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign byte_evt = s2_q & ~s3_q & ena;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= 2'b00;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
`ifdef NEUROCAM_TIMEOUT_EN
      tmr_q   <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
`ifdef NEUROCAM_TIMEOUT_EN
      tmr_q   <= tmr_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
`ifdef NEUROCAM_TIMEOUT_EN
    tmr_d   = tmr_q;
    tmo_d   = tmo_q;
`endif
    // Everything, including the handshake, freezes while ena is low.
    if (ena) begin
      unique case (state_q)
        StIdle: begin
          if (byte_evt) begin
            unique case (byte_in[7:6])
              2'b00: begin
                if (byte_in[0]) begin
                  ovf_d = 1'b0;
`ifdef NEUROCAM_TIMEOUT_EN
                  tmo_d = 1'b0;
`endif
                end
              end
              2'b11: begin
                op_d    = byte_in[7:6];
                addr_d  = byte_in[ADDR_W-1:0];
                data_d  = '0;
                state_d = StIssue;
              end
              default: begin
                op_d    = byte_in[7:6];
                addr_d  = byte_in[ADDR_W-1:0];
                data_d  = '0;
                cnt_d   = '0;
                state_d = StPayload;
`ifdef NEUROCAM_TIMEOUT_EN
                tmr_d   = '0;
`endif
              end
            endcase
          end
        end
        StPayload: begin
          if (byte_evt) begin
            // Shift left so the first payload byte ends up in the MSBs.
            data_d = (data_q << 8) | WORD_W'(byte_in);
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CntW'(WORD_BYTES - 1)) begin
              state_d = StIssue;
            end
`ifdef NEUROCAM_TIMEOUT_EN
            tmr_d = '0;
          end else if (tmr_q >= TmrW'(TIMEOUT_CYC)) begin
            data_d  = '0;
            tmo_d   = 1'b1;
            state_d = StIdle;
          end else begin
            tmr_d = tmr_q + 1'b1;
`endif
          end
        end
        StIssue: begin
          if (byte_evt) begin
            ovf_d = 1'b1;
          end
          if (req.req_ready) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign req.req_valid = (state_q == StIssue);
  assign req.req_op    = op_q;
  assign req.req_addr  = addr_q;
  assign req.req_data  = data_q;
  assign busy          = (state_q != StIdle);
  assign ovf           = ovf_q;
`ifdef NEUROCAM_TIMEOUT_EN
  assign tmo           = tmo_q;
`else
  assign tmo           = 1'b0;
`endif

endmodule

// File: doc/neurocam_host_if.md
Name: neurocam_host_if

Overview:
Host-side command front end for the neurocam core. It sits directly upstream of the CAM array. It takes bytes from the dedicated input pins, qualified by a host strobe on a bidirectional input pin. It frames them into WRITE/SEARCH/CLEAR/NOP commands and presents each completed command to the CAM core over a valid/ready request interface.

Parameters:
WORD_BYTES, 2, payload bytes per CAM word; WORD_W = 8*WORD_BYTES
ADDR_W, 3, CAM entry address width, taken from cmd byte bits [ADDR_W-1:0] (ADDR_W <= 6)
TIMEOUT_CYC, 255, payload inter-byte timeout in clk cycles (used only with NEUROCAM_TIMEOUT_EN)

Ports:
clk  in  1  system clock, single clock domain
rst_n  in  1  asynchronous active-low reset
ena  in  1  design enable; when low, strobe edges are ignored and all state is held
byte_in  in  8  host data byte (ui_in)
strb_in  in  1  host byte strobe, asynchronous to clk (uio_in[0])
req_valid  out  1  command request to CAM core
req_op  out  2  01=WRITE, 10=SEARCH, 11=CLEAR
req_addr  out  ADDR_W  target entry
req_data  out  WORD_W  write data or search key, first byte in MSBs
req_ready  in  1  CAM core accepts request
busy  out  1  high whenever FSM != IDLE
ovf  out  1  sticky: byte arrived while in ISSUE and was dropped
tmo  out  1  sticky: payload timeout abort (0 when feature compiled out)

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; req_valid=0, req_op=0, req_addr=0, req_data=0, busy=0, ovf=0, tmo=0; sync flops=0; byte counter=0.
- Strobe sync: strb_in passes through 2 flops (s1, s2) plus edge flop s3. Byte event = s2 & ~s3 & ena. byte_in is sampled on the byte-event edge, i.e. the 3rd rising clk edge after strb_in rises. Host holds byte_in stable from strobe rise through that edge and keeps the strobe high at least 3 cycles.
- Command byte: bits[7:6]=op, bits[ADDR_W-1:0]=addr.
- FSM IDLE, byte event, op decode:
  - 00 NOP: stay IDLE. If bit0=1, clear ovf and tmo in the same edge.
  - 11 CLEAR: latch op/addr, req_data=0, go to ISSUE.
  - 01/10: latch op/addr, clear req_data, cnt=0, go to PAYLOAD.
- FSM PAYLOAD: each byte event does req_data = {req_data[WORD_W-9:0], byte}, cnt++. On the byte with cnt==WORD_BYTES-1, go to ISSUE.
- FSM ISSUE: req_valid=1 from the first cycle in ISSUE; op/addr/data stable while valid. When req_valid & req_ready are both high at an edge, the request is accepted: FSM goes to IDLE and req_valid=0 the next cycle. Minimum latency from last byte event to req_valid high is 1 cycle.
- Byte event while in ISSUE: byte dropped, ovf<=1, FSM unaffected, including when it coincides with the handshake edge.
- ena low in any state: byte events suppressed, FSM and outputs hold, req_valid stays asserted if in ISSUE.
- Asynchronous reset mid-command: partial payload discarded, return to IDLE.
- req_ready is ignored when req_valid=0.

Optional Feature:
NEUROCAM_TIMEOUT_EN
- Defined:
  - An 8-bit-or-wider counter clears on entry to PAYLOAD and on each byte event, and increments each cycle in PAYLOAD while ena=1.
  - When it reaches TIMEOUT_CYC: FSM goes to IDLE, req_data is cleared, tmo<=1, and no request is issued.
- Not defined: no counter; PAYLOAD waits indefinitely; tmo tied 0.

Test Plan:
1. Reset then WRITE: bytes 0x45, 0xAB, 0xCD with req_ready=1 -> one req_valid pulse with req_op=01, req_addr=5, req_data=0xABCD; busy falls the cycle after the handshake.
2. SEARCH with stalled core: bytes 0x82, 0x12, 0x34 with req_ready=0 for 10 cycles, then 1 -> req_valid held 10+ cycles with req_op=10, addr=2, data=0x1234 stable; accepted exactly once.
3. CLEAR: byte 0xC7 -> req_op=11, req_addr=7, req_data=0x0000 on the cycle after the byte event.
4. Overrun: stall req_ready=0 and send extra byte 0xFF in ISSUE -> ovf=1 and req_data unchanged; then NOP 0x01 -> ovf=0.
5. ena/reset: ena=0 during payload strobes -> no capture; assert rst_n=0 after the first payload byte -> all outputs 0, and a new WRITE after reset completes correctly.
6. (NEUROCAM_TIMEOUT_EN, TIMEOUT_CYC=20) byte 0x41 then no strobe for 25 cycles -> tmo=1, busy=0, no req_valid; without the macro, busy stays 1.
